// File: rtl/chip_ram_arbiter_if.sv
// Request/grant bundle between the Agnus/CPU synchronizers, the chip-RAM arbiter
// and the SDRAM command sequencer.
interface chip_ram_arbiter_if;
    logic       SDRAM_CONFIGURED;
    logic       DMA_REQ;
    logic       CPU_REQ;
    logic       DBR_SYNC;
    logic       SEQ_DONE;
    logic       GNT_DMA;
    logic       GNT_CPU;
    logic       GNT_REF;
    logic [1:0] OWNER;
    logic [3:0] REF_DEBT;
    logic       DMA_OVERRUN;
    logic       WDOG_ERR;

    // Arbiter side
    modport slave (
        input  SDRAM_CONFIGURED, DMA_REQ, CPU_REQ, DBR_SYNC, SEQ_DONE,
        output GNT_DMA, GNT_CPU, GNT_REF, OWNER, REF_DEBT, DMA_OVERRUN, WDOG_ERR
    );

    // Requester / sequencer side
    modport master (
        output SDRAM_CONFIGURED, DMA_REQ, CPU_REQ, DBR_SYNC, SEQ_DONE,
        input  GNT_DMA, GNT_CPU, GNT_REF, OWNER, REF_DEBT, DMA_OVERRUN, WDOG_ERR
    );
endinterface

// File: rtl/chip_ram_arbiter.sv
// Chip-RAM SDRAM sequencer arbiter: DMA > urgent refresh > CPU > opportunistic refresh,
// with a refresh-interval timer, postponed-refresh debt and a BUSY watchdog.
module chip_ram_arbiter #(
    parameter int REF_INTERVAL = 624,
    parameter int REF_MAX      = 8,
    parameter int REF_URGENT   = 4,
    parameter int WDOG_CYCLES  = 31
) (
    input  logic              CLK80,
    input  logic              RESETn,
    chip_ram_arbiter_if.slave bus
);
    localparam int TMR_W = $clog2(REF_INTERVAL + 1);
    localparam int WDG_W = $clog2(WDOG_CYCLES + 1);

    localparam logic [TMR_W-1:0] TMR_LAST    = TMR_W'(REF_INTERVAL);
    localparam logic [WDG_W-1:0] WDG_LAST    = WDG_W'(WDOG_CYCLES - 1);
    localparam logic [3:0]       DEBT_MAX    = 4'(REF_MAX);
    localparam logic [3:0]       DEBT_URGENT = 4'(REF_URGENT);

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_DMA  = 2'b01;
    localparam logic [1:0] OWN_CPU  = 2'b10;
    localparam logic [1:0] OWN_REF  = 2'b11;

    typedef enum logic [1:0] {
        ST_INIT = 2'b00,
        ST_IDLE = 2'b01,
        ST_BUSY = 2'b10,
        ST_TURN = 2'b11
    } state_t;

    state_t             state_r, state_s;
    logic [TMR_W-1:0]   timer_r, timer_s;
    logic [WDG_W-1:0]   wdog_r, wdog_s;
    logic [3:0]         debt_r, debt_s;
    logic               dma_pend_r, dma_pend_s;
    logic               gnt_dma_r, gnt_dma_s;
    logic               gnt_cpu_r, gnt_cpu_s;
    logic               gnt_ref_r, gnt_ref_s;
    logic [1:0]         owner_r, owner_s;
    logic               overrun_r, overrun_s;
    logic               wdog_err_r, wdog_err_s;
    logic               tick_s;
    logic               dma_want_s;

    assign tick_s     = (timer_r == TMR_LAST);
    // A DMA_REQ seen in IDLE is granted on the same edge, giving next-cycle latency.
    assign dma_want_s = dma_pend_r | bus.DMA_REQ;

    // Arbitration FSM: next state, grant decisions, owner and watchdog.
    always_comb begin
        state_s    = state_r;
        gnt_dma_s  = 1'b0;
        gnt_cpu_s  = 1'b0;
        gnt_ref_s  = 1'b0;
        owner_s    = owner_r;
        wdog_s     = wdog_r;
        wdog_err_s = wdog_err_r;
        case (state_r)
            ST_INIT: begin
                owner_s = OWN_NONE;
                if (bus.SDRAM_CONFIGURED) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_INIT;
                end
            end
            ST_IDLE: begin
                wdog_s = {WDG_W{1'b0}};
                if (dma_want_s) begin
                    gnt_dma_s = 1'b1;
                    owner_s   = OWN_DMA;
                    state_s   = ST_BUSY;
                end else if (debt_r >= DEBT_URGENT) begin
                    gnt_ref_s = 1'b1;
                    owner_s   = OWN_REF;
                    state_s   = ST_BUSY;
                end else if (bus.CPU_REQ && bus.DBR_SYNC) begin
                    gnt_cpu_s = 1'b1;
                    owner_s   = OWN_CPU;
                    state_s   = ST_BUSY;
                end else if ((debt_r != 4'd0) && !bus.CPU_REQ) begin
                    gnt_ref_s = 1'b1;
                    owner_s   = OWN_REF;
                    state_s   = ST_BUSY;
                end else begin
                    owner_s = OWN_NONE;
                end
            end
            ST_BUSY: begin
                if (bus.SEQ_DONE) begin
                    owner_s = OWN_NONE;
                    state_s = ST_TURN;
                end else if (wdog_r == WDG_LAST) begin
                    wdog_err_s = 1'b1;
                    owner_s    = OWN_NONE;
                    state_s    = ST_TURN;
                end else begin
                    wdog_s = wdog_r + WDG_W'(1);
                end
            end
            ST_TURN: begin
                owner_s = OWN_NONE;
                state_s = ST_IDLE;
            end
            default: begin
                owner_s = OWN_NONE;
                state_s = ST_INIT;
            end
        endcase
    end

    // Refresh timer, refresh debt and DMA pending/overrun bookkeeping.
    always_comb begin
        timer_s    = timer_r + TMR_W'(1);
        debt_s     = debt_r;
        dma_pend_s = dma_pend_r | bus.DMA_REQ;
        overrun_s  = overrun_r;
        if (tick_s) begin
            timer_s = {TMR_W{1'b0}};
        end else begin
            timer_s = timer_r + TMR_W'(1);
        end
        if (tick_s && !gnt_ref_s) begin
            if (debt_r != DEBT_MAX) begin
                debt_s = debt_r + 4'd1;
            end else begin
                debt_s = debt_r;
            end
        end else if (gnt_ref_s && !tick_s) begin
            debt_s = debt_r - 4'd1;
        end else begin
            debt_s = debt_r;
        end
        // The grant consumes the oldest request; a second one arriving with it stays pending.
        if (gnt_dma_s) begin
            dma_pend_s = dma_pend_r & bus.DMA_REQ;
        end else begin
            dma_pend_s = dma_pend_r | bus.DMA_REQ;
        end
        if (bus.DMA_REQ && dma_pend_r && !gnt_dma_s) begin
            overrun_s = 1'b1;
        end else begin
            overrun_s = overrun_r;
        end
    end

    // State and output registers; everything advances on the falling edge of CLK80.
    always_ff @(negedge CLK80 or negedge RESETn) begin
        if (!RESETn) begin
            state_r    <= ST_INIT;
            timer_r    <= {TMR_W{1'b0}};
            wdog_r     <= {WDG_W{1'b0}};
            debt_r     <= 4'd0;
            dma_pend_r <= 1'b0;
            gnt_dma_r  <= 1'b0;
            gnt_cpu_r  <= 1'b0;
            gnt_ref_r  <= 1'b0;
            owner_r    <= OWN_NONE;
            overrun_r  <= 1'b0;
            wdog_err_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            timer_r    <= timer_s;
            wdog_r     <= wdog_s;
            debt_r     <= debt_s;
            dma_pend_r <= dma_pend_s;
            gnt_dma_r  <= gnt_dma_s;
            gnt_cpu_r  <= gnt_cpu_s;
            gnt_ref_r  <= gnt_ref_s;
            owner_r    <= owner_s;
            overrun_r  <= overrun_s;
            wdog_err_r <= wdog_err_s;
        end
    end

    assign bus.GNT_DMA     = gnt_dma_r;
    assign bus.GNT_CPU     = gnt_cpu_r;
    assign bus.GNT_REF     = gnt_ref_r;
    assign bus.OWNER       = owner_r;
    assign bus.REF_DEBT    = debt_r;
    assign bus.DMA_OVERRUN = overrun_r;
    assign bus.WDOG_ERR    = wdog_err_r;
endmodule

// File: tb/tb_chip_ram_arbiter.sv
// Directed bench for chip_ram_arbiter: inputs change and outputs are sampled on the
// rising edge of CLK80, away from the falling edge the design is clocked on.
module tb_chip_ram_arbiter;
    logic        CLK80 = 1'b0;
    logic        RESETn;
    int          checks = 0;
    int          errors = 0;
    int unsigned edges;

    chip_ram_arbiter_if bus();

    chip_ram_arbiter #(
        .REF_INTERVAL(624),
        .REF_MAX     (8),
        .REF_URGENT  (4),
        .WDOG_CYCLES (31)
    ) dut (
        .CLK80 (CLK80),
        .RESETn(RESETn),
        .bus   (bus.slave)
    );

    always #5 CLK80 = ~CLK80;

    // Falling edges since reset release; refresh ticks land on multiples of 625.
    always @(negedge CLK80 or negedge RESETn) begin
        if (!RESETn) edges <= 0;
        else         edges <= edges + 1;
    end

    task automatic cyc();
        @(posedge CLK80);
    endtask

    task automatic wait_gnt(input int budget, output int waited, output logic [2:0] g);
        int i;
        i = 0;
        waited = -1;
        g = 3'b000;
        while (i < budget && waited < 0) begin
            @(posedge CLK80);
            i++;
            if (bus.GNT_DMA || bus.GNT_CPU || bus.GNT_REF) begin
                g = {bus.GNT_REF, bus.GNT_CPU, bus.GNT_DMA};
                waited = i;
            end
        end
    endtask

    task automatic pulse_done();
        bus.SEQ_DONE = 1'b1;
        @(posedge CLK80);
        bus.SEQ_DONE = 1'b0;
    endtask

    function automatic logic [10:0] all_outs();
        return {bus.GNT_DMA, bus.GNT_CPU, bus.GNT_REF, bus.OWNER, bus.REF_DEBT,
                bus.DMA_OVERRUN, bus.WDOG_ERR};
    endfunction

    task automatic test_reset();
        RESETn = 1'b0;
        bus.SDRAM_CONFIGURED = 1'b0;
        bus.DMA_REQ = 1'b0;
        bus.CPU_REQ = 1'b0;
        bus.DBR_SYNC = 1'b0;
        bus.SEQ_DONE = 1'b0;
        repeat (3) cyc();
        checks++;
        if (all_outs() !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", all_outs(), 11'd0);
        end
        RESETn = 1'b1;
    endtask

    task automatic test_init_refresh();
        logic quiet;
        int w;
        logic [2:0] g;
        quiet = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            cyc();
            if (bus.GNT_DMA || bus.GNT_CPU || bus.GNT_REF) quiet = 1'b0;
            if (edges == 624) begin
                checks++;
                if (bus.REF_DEBT !== 4'd0) begin
                    errors++;
                    $display("FAIL debt_before_tick1: got %0d expected 0", bus.REF_DEBT);
                end
            end
            if (edges == 625) begin
                checks++;
                if (bus.REF_DEBT !== 4'd1) begin
                    errors++;
                    $display("FAIL debt_tick1: got %0d expected 1", bus.REF_DEBT);
                end
            end
            if (edges == 1875) begin
                checks++;
                if (bus.REF_DEBT !== 4'd3) begin
                    errors++;
                    $display("FAIL debt_tick3: got %0d expected 3", bus.REF_DEBT);
                end
            end
        end
        checks++;
        if (quiet !== 1'b1) begin
            errors++;
            $display("FAIL init_no_grant: got grant during INIT expected none");
        end
        bus.SDRAM_CONFIGURED = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_gnt(8, w, g);
            checks++;
            if (w !== 2 || g !== 3'b100 || bus.OWNER !== 2'b11 || bus.REF_DEBT !== 4'(2 - k)) begin
                errors++;
                $display("FAIL init_ref_grant%0d: got wait=%0d gnt=%b owner=%b debt=%0d expected wait=2 gnt=100 owner=11 debt=%0d",
                         k, w, g, bus.OWNER, bus.REF_DEBT, 2 - k);
            end
            pulse_done();
            checks++;
            if (bus.OWNER !== 2'b00) begin
                errors++;
                $display("FAIL init_ref_release%0d: got owner=%b expected 00", k, bus.OWNER);
            end
        end
        wait_gnt(6, w, g);
        checks++;
        if (w !== -1 || bus.REF_DEBT !== 4'd0) begin
            errors++;
            $display("FAIL debt_repaid: got wait=%0d debt=%0d expected no grant, debt 0", w, bus.REF_DEBT);
        end
    endtask

    task automatic test_dma_vs_cpu();
        int w;
        logic [2:0] g;
        bus.DMA_REQ = 1'b1;
        bus.CPU_REQ = 1'b1;
        bus.DBR_SYNC = 1'b1;
        cyc();
        bus.DMA_REQ = 1'b0;
        checks++;
        if ({bus.GNT_REF, bus.GNT_CPU, bus.GNT_DMA} !== 3'b001 || bus.OWNER !== 2'b01) begin
            errors++;
            $display("FAIL dma_first: got gnt=%b owner=%b expected gnt=001 owner=01",
                     {bus.GNT_REF, bus.GNT_CPU, bus.GNT_DMA}, bus.OWNER);
        end
        pulse_done();
        wait_gnt(6, w, g);
        checks++;
        if (w !== 2 || g !== 3'b010 || bus.OWNER !== 2'b10) begin
            errors++;
            $display("FAIL cpu_after_dma: got wait=%0d gnt=%b owner=%b expected wait=2 gnt=010 owner=10",
                     w, g, bus.OWNER);
        end
        bus.CPU_REQ = 1'b0;
        pulse_done();
        bus.DBR_SYNC = 1'b0;
    endtask

    task automatic test_dbr_gate();
        int w;
        logic [2:0] g;
        bus.CPU_REQ = 1'b1;
        bus.DBR_SYNC = 1'b0;
        wait_gnt(6, w, g);
        checks++;
        if (w !== -1) begin
            errors++;
            $display("FAIL dbr_blocks_cpu: got grant %b after %0d expected none", g, w);
        end
        bus.DBR_SYNC = 1'b1;
        wait_gnt(3, w, g);
        checks++;
        if (w !== 1 || g !== 3'b010) begin
            errors++;
            $display("FAIL dbr_release_cpu: got wait=%0d gnt=%b expected wait=1 gnt=010", w, g);
        end
        bus.CPU_REQ = 1'b0;
        pulse_done();
        bus.DBR_SYNC = 1'b0;
    endtask

    task automatic test_watchdog();
        logic held;
        repeat (2) cyc();
        bus.DMA_REQ = 1'b1;
        cyc();
        bus.DMA_REQ = 1'b0;
        checks++;
        if (bus.GNT_DMA !== 1'b1 || bus.OWNER !== 2'b01) begin
            errors++;
            $display("FAIL dma_latency: got gnt_dma=%b owner=%b expected 1/01", bus.GNT_DMA, bus.OWNER);
        end
        held = 1'b1;
        for (int j = 1; j <= 30; j++) begin
            cyc();
            if (bus.OWNER !== 2'b01 || bus.WDOG_ERR !== 1'b0) held = 1'b0;
        end
        checks++;
        if (held !== 1'b1) begin
            errors++;
            $display("FAIL wdog_early: got early release expected owner 01 for 30 cycles");
        end
        cyc();
        checks++;
        if (bus.WDOG_ERR !== 1'b1 || bus.OWNER !== 2'b00) begin
            errors++;
            $display("FAIL wdog_fire: got err=%b owner=%b expected 1/00", bus.WDOG_ERR, bus.OWNER);
        end
        repeat (2) cyc();
        bus.DMA_REQ = 1'b1;
        cyc();
        bus.DMA_REQ = 1'b0;
        checks++;
        if (bus.GNT_DMA !== 1'b1 || bus.OWNER !== 2'b01) begin
            errors++;
            $display("FAIL dma_after_wdog: got gnt_dma=%b owner=%b expected 1/01", bus.GNT_DMA, bus.OWNER);
        end
        pulse_done();
        checks++;
        if (bus.OWNER !== 2'b00 || bus.WDOG_ERR !== 1'b1) begin
            errors++;
            $display("FAIL wdog_sticky: got owner=%b err=%b expected 00/1", bus.OWNER, bus.WDOG_ERR);
        end
    endtask

    task automatic test_refresh_urgent();
        logic quiet;
        logic ref_seen;
        logic [2:0] exp_g;
        int cpu_grants;
        int rounds;
        int w;
        logic [2:0] g;
        bus.CPU_REQ = 1'b1;
        bus.DBR_SYNC = 1'b0;
        quiet = 1'b1;
        while (edges < 3130) begin
            cyc();
            if (bus.GNT_DMA || bus.GNT_CPU || bus.GNT_REF) quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1 || bus.REF_DEBT !== 4'd2) begin
            errors++;
            $display("FAIL debt_two: got quiet=%b debt=%0d expected 1/2", quiet, bus.REF_DEBT);
        end
        bus.DBR_SYNC = 1'b1;
        ref_seen = 1'b0;
        cpu_grants = 0;
        rounds = 0;
        while (!ref_seen && rounds < 600) begin
            wait_gnt(6, w, g);
            rounds++;
            // Decision edges after the 7th tick (edge 4375) see debt 4.
            exp_g = (edges >= 4376) ? 3'b100 : 3'b010;
            checks++;
            if (g !== exp_g) begin
                errors++;
                $display("FAIL urgent_order: got gnt=%b at edge %0d expected %b", g, edges, exp_g);
            end
            if (g == 3'b100) begin
                ref_seen = 1'b1;
                bus.DBR_SYNC = 1'b0;
                checks++;
                if (bus.REF_DEBT !== 4'd3) begin
                    errors++;
                    $display("FAIL urgent_debt: got %0d expected 3", bus.REF_DEBT);
                end
            end else begin
                cpu_grants++;
            end
            pulse_done();
        end
        checks++;
        if (ref_seen !== 1'b1 || cpu_grants < 400) begin
            errors++;
            $display("FAIL urgent_ref: got ref_seen=%b cpu_grants=%0d expected 1 and >=400",
                     ref_seen, cpu_grants);
        end
    endtask

    task automatic test_overrun_reset();
        int w;
        logic [2:0] g;
        repeat (2) cyc();
        bus.DBR_SYNC = 1'b1;
        wait_gnt(4, w, g);
        bus.DBR_SYNC = 1'b0;
        checks++;
        if (w !== 1 || g !== 3'b010) begin
            errors++;
            $display("FAIL busy_cpu: got wait=%0d gnt=%b expected wait=1 gnt=010", w, g);
        end
        bus.DMA_REQ = 1'b1;
        cyc();
        bus.DMA_REQ = 1'b0;
        checks++;
        if (bus.DMA_OVERRUN !== 1'b0) begin
            errors++;
            $display("FAIL overrun_first: got %b expected 0", bus.DMA_OVERRUN);
        end
        repeat (2) cyc();
        bus.DMA_REQ = 1'b1;
        cyc();
        bus.DMA_REQ = 1'b0;
        checks++;
        if (bus.DMA_OVERRUN !== 1'b1) begin
            errors++;
            $display("FAIL overrun_second: got %b expected 1", bus.DMA_OVERRUN);
        end
        pulse_done();
        wait_gnt(4, w, g);
        checks++;
        if (w !== 2 || g !== 3'b001 || bus.OWNER !== 2'b01) begin
            errors++;
            $display("FAIL overrun_grant: got wait=%0d gnt=%b owner=%b expected wait=2 gnt=001 owner=01",
                     w, g, bus.OWNER);
        end
        pulse_done();
        wait_gnt(6, w, g);
        checks++;
        if (w !== -1) begin
            errors++;
            $display("FAIL single_dma: got extra grant %b after %0d expected none", g, w);
        end
        bus.DMA_REQ = 1'b1;
        cyc();
        bus.DMA_REQ = 1'b0;
        cyc();
        checks++;
        if (bus.OWNER !== 2'b01) begin
            errors++;
            $display("FAIL busy_before_reset: got owner=%b expected 01", bus.OWNER);
        end
        RESETn = 1'b0;
        #1;
        checks++;
        if (all_outs() !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid_busy: got %b expected %b", all_outs(), 11'd0);
        end
        repeat (2) cyc();
        RESETn = 1'b1;
        repeat (3) cyc();
        checks++;
        if (all_outs() !== 11'd0) begin
            errors++;
            $display("FAIL after_reset: got %b expected %b", all_outs(), 11'd0);
        end
    endtask

    initial begin
        test_reset();
        test_init_refresh();
        test_dma_vs_cpu();
        test_dbr_gate();
        test_watchdog();
        test_refresh_urgent();
        test_overrun_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
